cla_adder_pipe: RTL and testbench

//  Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.

---
 rtl/cla_adder_pipe_pkg.sv | 37 +++
 rtl/cla_adder_pipe_group.sv | 22 ++
 rtl/cla_adder_pipe.sv | 141 ++++++++++++++
 tb/tb_cla_adder_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_adder_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   DEFAULT_WIDTH / DEFAULT_GROUP : default operand width and lookahead group size
//   num_groups()                  : number of first-level lookahead groups
//   lookahead()                   : flattened generate/propagate carry equation
package cla_adder_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_GROUP = 4;
  localparam int unsigned MAX_TERMS     = 64;

  function automatic int unsigned num_groups(input int unsigned width,
                                             input int unsigned group);
    return width / group;
  endfunction

  // Carry out of an n-bit span, written as the fully expanded sum of products
  //   c_n = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0] | p[n-1..0]cin
  // so every carry is two logic levels deep in g/p (no ripple chain).
  // With n = 0 this returns cin; with cin = 0 it is the span's generate term.
  function automatic logic lookahead(input logic [MAX_TERMS-1:0] g,
                                     input logic [MAX_TERMS-1:0] p,
                                     input logic                 cin,
                                     input int unsigned          n);
    logic carry;
    logic term;
    carry = 1'b0;
    for (int unsigned j = 0; j < n; j++) begin
      term = g[j[5:0]];
      for (int unsigned m = j + 1; m < n; m++) term &= p[m[5:0]];
      carry |= term;
    end
    term = cin;
    for (int unsigned m = 0; m < n; m++) term &= p[m[5:0]];
    return carry | term;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// One first-level lookahead group: produces the carry into every bit of the
// group from the registered per-bit propagate/generate and the group carry-in.
//   p_i[GROUP]     per-bit propagate (a ^ b')
//   g_i[GROUP]     per-bit generate  (a & b')
//   c_i            carry into bit 0 of the group (from the second-level lookahead)
//   carry_o[GROUP] carry into each bit of the group
module cla_adder_pipe_group
  import cla_adder_pipe_pkg::*;
#(
  parameter int unsigned GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] p_i,
  input  logic [GROUP-1:0] g_i,
  input  logic             c_i,
  output logic [GROUP-1:0] carry_o
);

  for (genvar i = 0; i < GROUP; i++) begin : g_bit
    assign carry_o[i] = lookahead(MAX_TERMS'(g_i), MAX_TERMS'(p_i), c_i, i);
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow.
//   clock, reset_n          rising-edge clock, async active-low reset
//   in_valid/in_ready       operand handshake (in_ready independent of in_valid)
//   in_a, in_b, in_cin      operands and carry-in (carry-in ignored when in_sub)
//   in_sub                  1: compute in_a - in_b
//   out_valid/out_ready     result handshake
//   out_sum, out_cout       result modulo 2^WIDTH and carry out (subtract: 1 = no borrow)
//   out_ovf, out_zero       signed overflow and zero flag of the stored result
// Stage 1 registers per-bit p/g and per-group P/G; stage 2 resolves all
// carries with a two-level lookahead and registers the sum and flags.
module cla_adder_pipe
  import cla_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GROUP = DEFAULT_GROUP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NGROUPS = num_groups(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0 || GROUP > MAX_TERMS || NGROUPS > MAX_TERMS) begin : g_param_check
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP, with at most 64 groups of at most 64 bits");
  end

  // ---------------- flow control ----------------
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, s1_load, s2_load;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;
  assign s2_load  = s1_valid_q && s2_adv;

  // ---------------- stage 1: propagate / generate ----------------
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   p_d, g_d, p_q, g_q;
  logic               c0_d, c0_q;
  logic [NGROUPS-1:0] grp_p_d, grp_g_d, grp_p_q, grp_g_q;

  // Subtraction is A + ~B + 1, so the carry-in is forced high.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign p_d   = in_a ^ b_eff;
  assign g_d   = in_a & b_eff;
  assign c0_d  = in_sub | in_cin;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_s1_group
    assign grp_p_d[k] = &p_d[k*GROUP +: GROUP];
    assign grp_g_d[k] = lookahead(MAX_TERMS'(g_d[k*GROUP +: GROUP]),
                                  MAX_TERMS'(p_d[k*GROUP +: GROUP]), 1'b0, GROUP);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      c0_q       <= 1'b0;
      grp_p_q    <= '0;
      grp_g_q    <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s1_load) begin
        p_q     <= p_d;
        g_q     <= g_d;
        c0_q    <= c0_d;
        grp_p_q <= grp_p_d;
        grp_g_q <= grp_g_d;
      end
    end
  end

  // ---------------- stage 2: carry resolution and sum ----------------
  logic [NGROUPS:0]  grp_c;
  logic [WIDTH-1:0]  carry;
  logic [WIDTH-1:0]  sum_d, sum_q;
  logic              cout_d, ovf_d, zero_d;
  logic              cout_q, ovf_q, zero_q;

  // Second-level lookahead: each group carry is expanded directly from c0
  // and the group P/G terms below it, not chained from the previous group.
  assign grp_c[0] = c0_q;
  for (genvar k = 0; k < NGROUPS; k++) begin : g_s2_group
    assign grp_c[k+1] = lookahead(MAX_TERMS'(grp_g_q), MAX_TERMS'(grp_p_q), c0_q, k + 1);

    cla_adder_pipe_group #(.GROUP(GROUP)) u_group (
      .p_i     (p_q[k*GROUP +: GROUP]),
      .g_i     (g_q[k*GROUP +: GROUP]),
      .c_i     (grp_c[k]),
      .carry_o (carry[k*GROUP +: GROUP])
    );
  end

  assign sum_d  = p_q ^ carry;
  assign cout_d = grp_c[NGROUPS];
  assign ovf_d  = carry[WIDTH-1] ^ cout_d;
  assign zero_d = ~|sum_d;

  // NOTE: the result registers are reset as well as the valid bit, so every
  // output reads zero while reset is held rather than showing stale data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench: a directed vector table and handshake sequences on the
// default 32/4 instance, plus random streams on 16/8 and 8/4 instances checked
// against a plain-arithmetic reference model through in-order scoreboards.
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  localparam int NRAND = 10000;

  int checks   = 0;
  int failures = 0;

  logic clock;
  logic reset_n;

  // 32/4 instance (directed)
  logic        v32, ir32, rdy32, ov32, cin32, sub32, co32, of32, z32;
  logic [31:0] a32, b32, sum32;

  // 16/8 and 8/4 instances share one random stimulus stream
  logic        rv, rcin, rsub, rrdy;
  logic [15:0] ra, rb;
  logic        ir16, ov16, co16, of16, z16;
  logic [15:0] s16;
  logic        ir8, ov8, co8, of8, z8;
  logic [7:0]  s8;

  cla_adder_pipe u_d32 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32), .in_cin(cin32), .in_sub(sub32),
    .out_valid(ov32), .out_ready(rdy32), .out_sum(sum32), .out_cout(co32), .out_ovf(of32), .out_zero(z32)
  );

  cla_adder_pipe #(.WIDTH(16), .GROUP(8)) u_d16 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(rv), .in_ready(ir16), .in_a(ra), .in_b(rb), .in_cin(rcin), .in_sub(rsub),
    .out_valid(ov16), .out_ready(rrdy), .out_sum(s16), .out_cout(co16), .out_ovf(of16), .out_zero(z16)
  );

  cla_adder_pipe #(.WIDTH(8), .GROUP(4)) u_d8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(rv), .in_ready(ir8), .in_a(ra[7:0]), .in_b(rb[7:0]), .in_cin(rcin), .in_sub(rsub),
    .out_valid(ov8), .out_ready(rrdy), .out_sum(s8), .out_cout(co8), .out_ovf(of8), .out_zero(z8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain w-bit arithmetic; overflow from operand/result signs.
  function automatic res_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, aa, bb, full;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, a} & mask;
    bb     = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    full   = aa + bb + {63'd0, (sub | cin)};
    r.sum  = 32'(full & mask);
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.zero = ((full & mask) == 64'd0);
    return r;
  endfunction

  function automatic res_t got32();
    return '{sum32, co32, of32, z32};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 6))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h807F;
      5:       return 16'h7F80;
      default: return 16'($urandom);
    endcase
  endfunction

  // Offer one beat to the 32-bit instance and wait (bounded) for its result.
  task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input res_t exp, input string name);
    int waited;
    @(negedge clock);
    a32 = a; b32 = b; cin32 = cin; sub32 = sub; v32 = 1'b1; rdy32 = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(ir32), 64'd1);
    @(negedge clock);
    v32 = 1'b0;
    waited = 0;
    #1;
    while (!ov32 && waited < 8) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (ov32) check(name, 64'(got32()), 64'(exp));
    else      check({name, "_timeout"}, 64'(ov32), 64'd1);
  endtask

  vec_t vecs[14];
  res_t exp4[4];
  logic [31:0] a4[4], b4[4];
  logic        s4[4];
  res_t q16[$], q8[$];

  initial begin
    int   sent, got, stale, got16, got8;
    res_t e;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, '{32'h0000_0004, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
    vecs[9]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, '{32'hACF1_3568, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, '{32'h0000_0001, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vecs[12] = '{32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_1000, 1'b0, 1'b0, 1'b0}};
    vecs[13] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};

    a4[0] = 32'd10;         b4[0] = 32'd20;         s4[0] = 1'b0;
    a4[1] = 32'hFFFF_FFF0;  b4[1] = 32'h20;         s4[1] = 1'b0;
    a4[2] = 32'd100;        b4[2] = 32'd1;          s4[2] = 1'b1;
    a4[3] = 32'd0;          b4[3] = 32'd1;          s4[3] = 1'b1;
    for (int i = 0; i < 4; i++) exp4[i] = model(32, a4[i], b4[i], 1'b0, s4[i]);

    reset_n = 1'b0;
    a32 = 32'd3; b32 = 32'd4; cin32 = 1'b0; sub32 = 1'b0; v32 = 1'b1; rdy32 = 1'b1;
    rv = 1'b0; ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0; rrdy = 1'b1;

    // Reset held with a beat offered: nothing emerges, outputs are zero.
    repeat (3) @(negedge clock);
    #1;
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_outputs", 64'(got32()), 64'd0);

    // First beat after release appears exactly two cycles later.
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    v32 = 1'b0;
    #1;
    check("lat_cycle1_valid", 64'(ov32), 64'd0);
    @(negedge clock);
    #1;
    check("lat_cycle2_valid", 64'(ov32), 64'd1);
    check("lat_result", 64'(got32()), 64'(model(32, 32'd3, 32'd4, 1'b0, 1'b0)));

    // Directed add/subtract vectors.
    for (int i = 0; i < 14; i++)
      run_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp, $sformatf("vec%0d", i));

    // Backpressure: four beats, consumer stalled for the first three cycles.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clock);
      v32 = (sent < 4);
      if (sent < 4) begin
        a32 = a4[sent]; b32 = b4[sent]; sub32 = s4[sent]; cin32 = 1'b0;
      end
      rdy32 = (cyc >= 3);
      #1;
      if (cyc == 2) check("bp_in_ready_full", 64'(ir32), 64'd0);
      if (ov32 && !rdy32 && cyc >= 1) check($sformatf("bp_hold_c%0d", cyc), 64'(got32()), 64'(exp4[0]));
      if (ov32 && rdy32) begin
        check($sformatf("bp_result%0d", got), 64'(got32()), 64'(exp4[got]));
        got++;
      end
      if (v32 && ir32) sent++;
    end
    check("bp_all_results", 64'(got), 64'd4);
    @(negedge clock);
    v32 = 1'b0;

    // Reset with both stages full: output drops at once, nothing stale after.
    @(negedge clock);
    rdy32 = 1'b0; v32 = 1'b1; a32 = 32'd11; b32 = 32'd22; sub32 = 1'b0;
    @(negedge clock);
    a32 = 32'd33; b32 = 32'd44;
    @(negedge clock);
    v32 = 1'b0;
    #1;
    check("mid_full_in_ready", 64'(ir32), 64'd0);
    check("mid_full_out_valid", 64'(ov32), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ov32), 64'd0);
    check("mid_rst_outputs", 64'(got32()), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy32 = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clock);
      #1;
      if (ov32) stale++;
    end
    check("mid_rst_no_stale", 64'(stale), 64'd0);

    // Random streams on the 16/8 and 8/4 instances with random stalls.
    sent = 0;
    got16 = 0;
    got8 = 0;
    for (int cyc = 0; cyc < 60000 && (got16 < NRAND || got8 < NRAND); cyc++) begin
      @(negedge clock);
      rv   = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      ra   = pick();
      rb   = pick();
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      rrdy = ($urandom_range(0, 9) < 7);
      #1;
      if (ov16 && rrdy) begin
        if (q16.size() > 0) begin
          e = q16.pop_front();
          check("rand16", 64'(res_t'{32'(s16), co16, of16, z16}), 64'(e));
        end else check("rand16_unexpected_out_valid", 64'(ov16), 64'd0);
        got16++;
      end
      if (ov8 && rrdy) begin
        if (q8.size() > 0) begin
          e = q8.pop_front();
          check("rand8", 64'(res_t'{32'(s8), co8, of8, z8}), 64'(e));
        end else check("rand8_unexpected_out_valid", 64'(ov8), 64'd0);
        got8++;
      end
      if (rv && ir16) q16.push_back(model(16, 32'(ra), 32'(rb), rcin, rsub));
      if (rv && ir8)  q8.push_back(model(8, 32'(ra[7:0]), 32'(rb[7:0]), rcin, rsub));
      if (rv && ir16) sent++;
    end
    rv = 1'b0;
    check("rand16_count", 64'(got16), 64'(NRAND));
    check("rand8_count", 64'(got8), 64'(NRAND));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
